ander_serial: RTL and testbench

//  Bit-serial, handshaked counterpart of the combinational ander: accepts an operand pair,

---
 rtl/ander_serial.sv | 111 +++++++++++
 tb/tb_ander_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ander_serial.sv
// Bit-serial AND with valid/ready handshakes: one operand bit per clock, LSB first.
// Optional ZERO_FLAG_EN adds the registered out_zero flag.
module ander_serial #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out,
    output logic            busy
`ifdef ZERO_FLAG_EN
    ,
    output logic            out_zero
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on state and rst; out_valid holds until out_ready takes it.
    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] a, b, res, res_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last_bit;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The single 1-bit AND lands in the result bit selected by the counter.
    always_comb begin
        res_nxt = res;
        for (int i = 0; i < SIZE; i++) begin
            if (cnt == CW'(i)) res_nxt[i] = a[0] & b[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            res      <= '0;
            cnt      <= '0;
            out      <= '0;
`ifdef ZERO_FLAG_EN
            out_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a   <= in1;
                        b   <= in2;
                        cnt <= '0;
                        res <= '0;
                    end
                end
                BUSY: begin
                    a   <= a >> 1;
                    b   <= b >> 1;
                    cnt <= cnt + CW'(1);
                    res <= res_nxt;
                    // out only ever changes here, on the way into DONE
                    if (last_bit) begin
                        out      <= res_nxt;
`ifdef ZERO_FLAG_EN
                        out_zero <= ~|res_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ander_serial.sv
// Directed bench for ander_serial: SIZE=8 instance for the main scenarios, SIZE=1 for the corner case.
module tb_ander_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [7:0] in1, in2;
    logic       in_ready, out_valid, busy;
    logic [7:0] out;

    logic       s_in_valid, s_out_ready;
    logic [0:0] s_in1, s_in2;
    logic       s_in_ready, s_out_valid, s_busy;
    logic [0:0] s_out;
`ifdef ZERO_FLAG_EN
    logic       out_zero, s_out_zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ander_serial #(.SIZE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
`ifdef ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    ander_serial #(.SIZE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in1(s_in1), .in2(s_in2), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out(s_out), .busy(s_busy)
`ifdef ZERO_FLAG_EN
        , .out_zero(s_out_zero)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair on the SIZE=8 instance, then count cycles until out_valid (bounded).
    task automatic run_pair(input logic [7:0] x, input logic [7:0] y, output int cycles);
        in1 = x; in2 = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in1 = 8'hFF; in2 = 8'hFF; out_ready = 1'b1;
        s_in_valid = 1'b1; s_in1 = 1'b1; s_in2 = 1'b1; s_out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_vec++;
        if ({out_valid, busy, out} !== 10'b0) begin
            n_err++; $display("FAIL reset_outputs got ov=%b busy=%b out=%h exp all 0", out_valid, busy, out);
        end
`ifdef ZERO_FLAG_EN
        n_vec++;
        if (out_zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", out_zero); end
`endif
        in_valid = 1'b0; s_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        run_pair(8'hAA, 8'hCC, cyc);
        n_vec++;
        if (cyc !== 8) begin n_err++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
        n_vec++;
        if (out !== 8'h88) begin n_err++; $display("FAIL basic_out got=%h exp=88", out); end
`ifdef ZERO_FLAG_EN
        n_vec++;
        if (out_zero !== 1'b0) begin n_err++; $display("FAIL basic_zero got=%b exp=0", out_zero); end
`endif
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h88) begin
            n_err++; $display("FAIL basic_idle got ov=%b ir=%b out=%h exp ov=0 ir=1 out=88", out_valid, in_ready, out);
        end
    endtask

    task automatic test_zero();
        int cyc;
        out_ready = 1'b1;
        run_pair(8'hFF, 8'h00, cyc);
        n_vec++;
        if (out_valid !== 1'b1 || out !== 8'h00) begin
            n_err++; $display("FAIL zero_out got ov=%b out=%h exp ov=1 out=00", out_valid, out);
        end
`ifdef ZERO_FLAG_EN
        n_vec++;
        if (out_zero !== 1'b1) begin n_err++; $display("FAIL zero_flag got=%b exp=1", out_zero); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        run_pair(8'h3C, 8'h5A, cyc);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out !== 8'h18 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got ov=%b out=%h ir=%b exp ov=1 out=18 ir=0", i, out_valid, out, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        out_ready = 1'b0;
        in1 = 8'hAA; in2 = 8'hCC; in_valid = 1'b1;
        tick();
        in1 = 8'h0F; in2 = 8'hFF;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            n_vec++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL busy_flags[%0d] got ir=%b busy=%b exp ir=0 busy=1", cyc, in_ready, busy);
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (out !== 8'h88 || cyc !== 8) begin
            n_err++; $display("FAIL busy_first got out=%h cyc=%0d exp out=88 cyc=8", out, cyc);
        end
        out_ready = 1'b1;
        tick();
        // back in IDLE with in_valid still high: second pair accepted on this edge
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (out !== 8'h0F || cyc !== 8) begin
            n_err++; $display("FAIL busy_second got out=%h cyc=%0d exp out=0f cyc=8", out, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        out_ready = 1'b1;
        in1 = 8'hFF; in2 = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got out=%h ov=%b busy=%b ir=%b exp 00/0/0/0", out, out_valid, busy, in_ready);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_spurious got=%b exp=0", seen); end
    endtask

    task automatic test_size1();
        int accepts, last_acc, gap_bad;
        s_out_ready = 1'b1;
        s_in1 = 1'b1; s_in2 = 1'b1; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        tick();
        n_vec++;
        if (s_out_valid !== 1'b1 || s_out !== 1'b1) begin
            n_err++; $display("FAIL s1_single got ov=%b out=%b exp ov=1 out=1", s_out_valid, s_out);
        end
        tick();
        s_in1 = 1'b1; s_in2 = 1'b0; s_in_valid = 1'b1;
        accepts = 0; last_acc = -1; gap_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (s_in_valid && s_in_ready) begin
                if (last_acc >= 0 && i - last_acc != 3) gap_bad++;
                last_acc = i;
                accepts++;
            end
            tick();
        end
        s_in_valid = 1'b0;
        n_vec++;
        if (accepts !== 4 || gap_bad !== 0) begin
            n_err++; $display("FAIL s1_b2b got accepts=%0d bad_gaps=%0d exp accepts=4 bad_gaps=0", accepts, gap_bad);
        end
        n_vec++;
        if (s_out !== 1'b0) begin n_err++; $display("FAIL s1_b2b_out got=%b exp=0", s_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_busy();
        test_size1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
